// File: rtl/serializer_gen2.sv
// serializer_gen2: parallel-to-serial converter for the UART TX path.
// Shifts on an external bit-rate tick and reloads on the last tick, so back-to-back words leave no gap.
module serializer_gen2 #(
   parameter int   DATA_WIDTH = 8,
   parameter bit   MSB_FIRST  = 1'b0,
   parameter logic IDLE_LEVEL = 1'b1,
   localparam int  CNT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  Serializer_CLK,
   input  logic                  Serializer_RST_ASYN,
   input  logic [DATA_WIDTH-1:0] Serializer_ParallelData,
   input  logic                  Serializer_Valid,
   output logic                  Serializer_Ready,
   input  logic                  Serializer_En,
   output logic                  Serializer_SerialData,
   output logic                  Serializer_Busy,
   output logic                  Serializer_Done
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [DATA_WIDTH-1:0] w_shreg_nxt;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_busy;
   logic                  w_tick;
   logic                  w_last;
   logic                  w_ready;
   logic                  w_load;
   logic                  w_out_bit;

   assign w_busy  = (r_state == S_SHIFT);
   assign w_tick  = w_busy & Serializer_En;
   assign w_last  = w_tick & (r_cnt == LAST_CNT);
   assign w_ready = (r_state == S_IDLE) | w_last;
   assign w_load  = Serializer_Valid & w_ready;

   // Bit order selects shift direction and which end of the word feeds the line.
   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shifted = {r_shreg[DATA_WIDTH-2:0], 1'b0};
         assign w_out_bit = r_shreg[DATA_WIDTH-1];
      end else begin : g_lsb
         assign w_shifted = {1'b0, r_shreg[DATA_WIDTH-1:1]};
         assign w_out_bit = r_shreg[0];
      end
   endgenerate

   // State, shift register and bit counter update.
   always_ff @(posedge Serializer_CLK or negedge Serializer_RST_ASYN) begin
      if (!Serializer_RST_ASYN) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: a load (from IDLE or on the last tick) beats everything else.
   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      if (w_load) begin
         w_state_nxt = S_SHIFT;
         w_shreg_nxt = Serializer_ParallelData;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               w_state_nxt = S_IDLE;
            end
            S_SHIFT: begin
               if (w_last) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else if (w_tick) begin
                  w_shreg_nxt = w_shifted;
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign Serializer_Ready      = w_ready;
   assign Serializer_Done       = w_last;
   assign Serializer_Busy       = w_busy;
   assign Serializer_SerialData = w_busy ? w_out_bit : IDLE_LEVEL;

endmodule

// File: tb/tb_serializer_gen2.sv
// tb_serializer_gen2: directed checks of serializer_gen2 in LSB-first,
// MSB-first and 5-bit configurations.
module tb_serializer_gen2;

   logic       clk;
   logic       rst_n;

   logic       a_valid, a_en, a_ready, a_sd, a_busy, a_done;
   logic [7:0] a_data;
   logic       b_valid, b_en, b_ready, b_sd, b_busy, b_done;
   logic [7:0] b_data;
   logic       c_valid, c_en, c_ready, c_sd, c_busy, c_done;
   logic [4:0] c_data;

   int n_chk;
   int n_fail;

   bit exp_d2_lsb[8]  = '{0, 1, 0, 0, 1, 0, 1, 1};
   bit exp_d2_msb[8]  = '{1, 1, 0, 1, 0, 0, 1, 0};
   bit exp_b2b[16]    = '{0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
   bit exp_w5[5]      = '{0, 1, 1, 0, 1};

   serializer_gen2 #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb8 (
      .Serializer_CLK          (clk),
      .Serializer_RST_ASYN     (rst_n),
      .Serializer_ParallelData (a_data),
      .Serializer_Valid        (a_valid),
      .Serializer_Ready        (a_ready),
      .Serializer_En           (a_en),
      .Serializer_SerialData   (a_sd),
      .Serializer_Busy         (a_busy),
      .Serializer_Done         (a_done)
   );

   serializer_gen2 #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb8 (
      .Serializer_CLK          (clk),
      .Serializer_RST_ASYN     (rst_n),
      .Serializer_ParallelData (b_data),
      .Serializer_Valid        (b_valid),
      .Serializer_Ready        (b_ready),
      .Serializer_En           (b_en),
      .Serializer_SerialData   (b_sd),
      .Serializer_Busy         (b_busy),
      .Serializer_Done         (b_done)
   );

   serializer_gen2 #(.DATA_WIDTH(5), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_w5 (
      .Serializer_CLK          (clk),
      .Serializer_RST_ASYN     (rst_n),
      .Serializer_ParallelData (c_data),
      .Serializer_Valid        (c_valid),
      .Serializer_Ready        (c_ready),
      .Serializer_En           (c_en),
      .Serializer_SerialData   (c_sd),
      .Serializer_Busy         (c_busy),
      .Serializer_Done         (c_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int busy_cnt;
      n_chk  = 0;
      n_fail = 0;
      a_valid = 0; a_en = 0; a_data = '0;
      b_valid = 0; b_en = 0; b_data = '0;
      c_valid = 0; c_en = 0; c_data = '0;
      rst_n = 1'b0;

      // reset state
      #2;
      chk("rst_sd",    {31'd0, a_sd},    32'd1);
      chk("rst_busy",  {31'd0, a_busy},  32'd0);
      chk("rst_ready", {31'd0, a_ready}, 32'd1);
      chk("rst_done",  {31'd0, a_done},  32'd0);
      chk("rst_b_sd",  {31'd0, b_sd},    32'd1);
      chk("rst_c_cnt", {29'd0, u_w5.r_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cyc();

      // LSB-first 0xD2, En every cycle, En also high on the load cycle
      a_valid = 1; a_data = 8'hD2; a_en = 1;
      #1;
      chk("t1_ready_idle", {31'd0, a_ready}, 32'd1);
      chk("t1_done_idle",  {31'd0, a_done},  32'd0);
      next_cyc();
      a_valid = 0; a_data = 8'h00;
      busy_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("t1_sd",    {31'd0, a_sd},    {31'd0, exp_d2_lsb[k]});
         chk("t1_done",  {31'd0, a_done},  (k == 7) ? 32'd1 : 32'd0);
         chk("t1_ready", {31'd0, a_ready}, (k == 7) ? 32'd1 : 32'd0);
         if (a_busy) busy_cnt++;
         next_cyc();
      end
      a_en = 0;
      #1;
      chk("t1_busy_cnt", busy_cnt, 32'd8);
      chk("t1_sd_idle",  {31'd0, a_sd},   32'd1);
      chk("t1_busy_end", {31'd0, a_busy}, 32'd0);
      next_cyc();

      // MSB-first 0xD2, En every 4th cycle
      b_valid = 1; b_data = 8'hD2;
      next_cyc();
      b_valid = 0;
      busy_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         for (int p = 0; p < 4; p++) begin
            b_en = (p == 3);
            #1;
            chk("t2_sd",    {31'd0, b_sd},    {31'd0, exp_d2_msb[k]});
            chk("t2_ready", {31'd0, b_ready}, (k == 7 && p == 3) ? 32'd1 : 32'd0);
            chk("t2_done",  {31'd0, b_done},  (k == 7 && p == 3) ? 32'd1 : 32'd0);
            if (b_busy) busy_cnt++;
            next_cyc();
         end
      end
      b_en = 0;
      #1;
      chk("t2_busy_cnt", busy_cnt, 32'd32);
      chk("t2_busy_end", {31'd0, b_busy}, 32'd0);
      chk("t2_sd_idle",  {31'd0, b_sd},   32'd1);
      next_cyc();

      // back-to-back 0xD2 then 0x0F with Valid held
      a_valid = 1; a_data = 8'hD2; a_en = 1;
      next_cyc();
      a_data = 8'h0F;
      for (int i = 0; i < 16; i++) begin
         if (i >= 8) a_valid = 0;
         #1;
         chk("t3_sd",   {31'd0, a_sd},   {31'd0, exp_b2b[i]});
         chk("t3_busy", {31'd0, a_busy}, 32'd1);
         chk("t3_done", {31'd0, a_done}, (i == 7 || i == 15) ? 32'd1 : 32'd0);
         next_cyc();
      end
      a_en = 0;
      #1;
      chk("t3_busy_end", {31'd0, a_busy}, 32'd0);
      next_cyc();

      // 5-bit width, 5'b10110 LSB first
      c_valid = 1; c_data = 5'b10110;
      next_cyc();
      c_valid = 0; c_en = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_sd",   {31'd0, c_sd},        {31'd0, exp_w5[i]});
         chk("t4_cnt",  {29'd0, u_w5.r_cnt},  i);
         chk("t4_done", {31'd0, c_done},      (i == 4) ? 32'd1 : 32'd0);
         next_cyc();
      end
      c_en = 0;
      #1;
      chk("t4_cnt_idle", {29'd0, u_w5.r_cnt}, 32'd0);
      chk("t4_busy_end", {31'd0, c_busy},     32'd0);
      chk("t4_sd_idle",  {31'd0, c_sd},       32'd1);
      next_cyc();

      // ignored load while mid-frame
      a_valid = 1; a_data = 8'h00;
      next_cyc();
      a_valid = 0; a_en = 1;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            a_valid = 1; a_data = 8'hFF;
         end else begin
            a_valid = 0; a_data = 8'h00;
         end
         #1;
         if (i == 2) chk("t5_ready_lo", {31'd0, a_ready}, 32'd0);
         chk("t5_sd",   {31'd0, a_sd},   32'd0);
         chk("t5_done", {31'd0, a_done}, (i == 7) ? 32'd1 : 32'd0);
         next_cyc();
      end
      a_valid = 0; a_en = 0;
      #1;
      chk("t5_busy_end", {31'd0, a_busy}, 32'd0);
      chk("t5_sd_idle",  {31'd0, a_sd},   32'd1);
      next_cyc();

      // mid-frame reset after 3 bits, then fresh load of 0x01
      a_valid = 1; a_data = 8'h00;
      next_cyc();
      a_valid = 0; a_en = 1;
      for (int i = 0; i < 3; i++) next_cyc();
      a_en = 0;
      #1;
      chk("t6_busy_pre", {31'd0, a_busy}, 32'd1);
      chk("t6_sd_pre",   {31'd0, a_sd},   32'd0);
      rst_n = 1'b0;
      #1;
      chk("t6_sd_rst",    {31'd0, a_sd},    32'd1);
      chk("t6_busy_rst",  {31'd0, a_busy},  32'd0);
      chk("t6_ready_rst", {31'd0, a_ready}, 32'd1);
      next_cyc();
      rst_n = 1'b1;
      next_cyc();
      a_valid = 1; a_data = 8'h01; a_en = 1;
      #1;
      chk("t6_ready_ld", {31'd0, a_ready}, 32'd1);
      next_cyc();
      a_valid = 0;
      #1;
      chk("t6_first_bit", {31'd0, a_sd},   32'd1);
      chk("t6_busy",      {31'd0, a_busy}, 32'd1);
      next_cyc();
      #1;
      chk("t6_second_bit", {31'd0, a_sd}, 32'd0);
      a_en = 1;
      for (int i = 0; i < 7; i++) next_cyc();
      a_en = 0;
      #1;
      chk("t6_busy_end", {31'd0, a_busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
